scs8hd_a311oi_bist_ctrl: RTL and testbench

Built-in self-test sequencer for one scs8hd_a311oi cell under test (CUT). It walks all 32 input combinations of A1/A2/A3/B1/C1 and waits a programmable settle time after each. It then samples the cell's Y and compares it against the golden function Y = !((A1&A2&A3)|B1|C1), accumulating mismatches. It sits between the test-mode register block and the CUT, which it drives directly, and reports pass/fail plus the first failing vector.

---
 rtl/scs8hd_a311oi_bist_ctrl.sv | 131 +++++++++++++
 tb/tb_scs8hd_a311oi_bist_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/scs8hd_a311oi_bist_ctrl.sv
// BIST sequencer for a single a311oi cell: sweeps all 32 input vectors,
// compares Y against !((A1&A2&A3)|B1|C1) and records error count and first failure.
`timescale 1ns/1ps
module scs8hd_a311oi_bist_ctrl #(
  parameter int unsigned SETTLE = 2
) (
  input  logic       CLK,
  input  logic       RESET_B,
  input  logic       START,
  input  logic       ABORT,
  input  logic       Y_CUT,
  output logic       A1,
  output logic       A2,
  output logic       A3,
  output logic       B1,
  output logic       C1,
  output logic       BUSY,
  output logic       DONE,
  output logic       PASS,
  output logic [5:0] ERR_CNT,
  output logic [4:0] FIRST_FAIL,
  output logic       FIRST_FAIL_VLD
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_WAIT,
    S_SAMPLE,
    S_FIN
  } state_t;

  localparam logic [3:0] WAIT_LAST = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);

  state_t      r_state;
  logic [4:0]  r_vec;
  logic [3:0]  r_wait;
  logic [4:0]  r_pins;
  logic        r_busy;
  logic        r_done;
  logic        r_pass;
  logic [5:0]  r_err_cnt;
  logic [4:0]  r_first_fail;
  logic        r_first_vld;

  logic        w_exp;
  logic        w_miss;
  logic [5:0]  w_err_nxt;

  // Golden Y is high only when B1=C1=0 and the A-term is not all ones.
  assign w_exp     = (r_vec[1:0] == 2'b00) && !(r_vec[4] & r_vec[3] & r_vec[2]);
  assign w_miss    = (Y_CUT != w_exp);
  assign w_err_nxt = r_err_cnt + {5'd0, w_miss};

  always_ff @(posedge CLK) begin
    if (!RESET_B) begin
      r_state      <= S_IDLE;
      r_vec        <= '0;
      r_wait       <= '0;
      r_pins       <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_err_cnt    <= '0;
      r_first_fail <= '0;
      r_first_vld  <= 1'b0;
    end else if (ABORT && (r_state inside {S_APPLY, S_WAIT, S_SAMPLE})) begin
      // Error count and first-fail capture survive the abort for debug.
      r_state <= S_IDLE;
      r_pins  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_FIN: begin
          if (START) begin
            r_state      <= S_APPLY;
            r_vec        <= '0;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_err_cnt    <= '0;
            r_first_fail <= '0;
            r_first_vld  <= 1'b0;
          end
        end
        S_APPLY: begin
          r_pins  <= r_vec;
          r_wait  <= '0;
          r_state <= (SETTLE == 0) ? S_SAMPLE : S_WAIT;
        end
        S_WAIT: begin
          if (r_wait == WAIT_LAST) begin
            r_state <= S_SAMPLE;
          end else begin
            r_wait <= r_wait + 4'd1;
          end
        end
        S_SAMPLE: begin
          r_err_cnt <= w_err_nxt;
          if (w_miss && !r_first_vld) begin
            r_first_fail <= r_vec;
            r_first_vld  <= 1'b1;
          end
          if (r_vec == 5'd31) begin
            r_state <= S_FIN;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_err_nxt == '0);
          end else begin
            r_vec   <= r_vec + 5'd1;
            r_state <= S_APPLY;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign {A1, A2, A3, B1, C1} = r_pins;
  assign BUSY           = r_busy;
  assign DONE           = r_done;
  assign PASS           = r_pass;
  assign ERR_CNT        = r_err_cnt;
  assign FIRST_FAIL     = r_first_fail;
  assign FIRST_FAIL_VLD = r_first_vld;

endmodule

// File: tb/tb_scs8hd_a311oi_bist_ctrl.sv
// Directed bench for the a311oi BIST sequencer: two instances (SETTLE=2 and 0)
// driven against behavioural CUT models (ideal, stuck-at-0, C1 ignored).
`timescale 1ns/1ps
module tb_scs8hd_a311oi_bist_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start;
  logic        abort;
  logic        sel;
  int unsigned mode;

  logic [4:0] a_pins, b_pins;
  logic       a_busy, a_done, a_pass, a_vld, b_busy, b_done, b_pass, b_vld;
  logic [5:0] a_err, b_err;
  logic [4:0] a_ff, b_ff;
  logic       a_y, b_y;

  function automatic logic cut(input logic [4:0] p, input int unsigned m);
    case (m)
      0:       cut = !((p[4] & p[3] & p[2]) | p[1] | p[0]);
      1:       cut = 1'b0;
      default: cut = !((p[4] & p[3] & p[2]) | p[1]);
    endcase
  endfunction

  assign a_y = cut(a_pins, mode);
  assign b_y = cut(b_pins, mode);

  scs8hd_a311oi_bist_ctrl #(.SETTLE(2)) u_dut_a (
    .CLK(clk), .RESET_B(rst_n), .START(start & ~sel), .ABORT(abort), .Y_CUT(a_y),
    .A1(a_pins[4]), .A2(a_pins[3]), .A3(a_pins[2]), .B1(a_pins[1]), .C1(a_pins[0]),
    .BUSY(a_busy), .DONE(a_done), .PASS(a_pass), .ERR_CNT(a_err),
    .FIRST_FAIL(a_ff), .FIRST_FAIL_VLD(a_vld)
  );

  scs8hd_a311oi_bist_ctrl #(.SETTLE(0)) u_dut_b (
    .CLK(clk), .RESET_B(rst_n), .START(start & sel), .ABORT(abort), .Y_CUT(b_y),
    .A1(b_pins[4]), .A2(b_pins[3]), .A3(b_pins[2]), .B1(b_pins[1]), .C1(b_pins[0]),
    .BUSY(b_busy), .DONE(b_done), .PASS(b_pass), .ERR_CNT(b_err),
    .FIRST_FAIL(b_ff), .FIRST_FAIL_VLD(b_vld)
  );

  logic [4:0] o_pins, o_ff;
  logic [5:0] o_err;
  logic       o_busy, o_done, o_pass, o_vld;
  assign o_pins = sel ? b_pins : a_pins;
  assign o_busy = sel ? b_busy : a_busy;
  assign o_done = sel ? b_done : a_done;
  assign o_pass = sel ? b_pass : a_pass;
  assign o_err  = sel ? b_err  : a_err;
  assign o_ff   = sel ? b_ff   : a_ff;
  assign o_vld  = sel ? b_vld  : a_vld;

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pins(input logic [4:0] v, input string name);
    int unsigned t = 0;
    while (o_pins !== v && t < 500) begin
      tick();
      t++;
    end
    n_chk++;
    if (o_pins !== v) $display("FAIL %s: pins=%0d want %0d (timeout)", name, o_pins, v);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; sel = 1'b0; mode = 0;
    tick(); tick();
    n_chk++;
    if ({a_pins, a_busy, a_done, a_pass, a_err, a_ff, a_vld} !== '0)
      $display("FAIL reset_a: got %h want 0", {a_pins, a_busy, a_done, a_pass, a_err, a_ff, a_vld});
    else n_pass++;
    n_chk++;
    if ({b_pins, b_busy, b_done, b_pass, b_err, b_ff, b_vld} !== '0)
      $display("FAIL reset_b: got %h want 0", {b_pins, b_busy, b_done, b_pass, b_err, b_ff, b_vld});
    else n_pass++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic run_full(input int unsigned m, input logic s, input int unsigned cyc_exp,
                          input int unsigned poke, input logic exp_pass, input logic [5:0] exp_err,
                          input logic [4:0] exp_ff, input logic exp_vld, input string name);
    int unsigned cyc;
    int unsigned bcnt;
    sel = s; mode = m;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_chk++;
    if (o_busy !== 1'b1 || o_done !== 1'b0 || o_err !== 6'd0 || o_vld !== 1'b0)
      $display("FAIL %s_start: busy=%b done=%b err=%0d vld=%b want 1 0 0 0", name, o_busy, o_done, o_err, o_vld);
    else n_pass++;
    bcnt = o_busy;
    tick();
    bcnt += o_busy;
    n_chk++;
    if (o_pins !== 5'd0) $display("FAIL %s_vec0: pins=%0d want 0", name, o_pins);
    else n_pass++;
    cyc = 1;
    while (!o_done && cyc < 2000) begin
      if (poke != 0 && cyc == poke) start = 1'b1;
      tick();
      start = 1'b0;
      cyc++;
      bcnt += o_busy;
    end
    n_chk++;
    if (cyc !== cyc_exp) $display("FAIL %s_len: cycles=%0d want %0d", name, cyc, cyc_exp);
    else n_pass++;
    n_chk++;
    if (bcnt !== cyc_exp) $display("FAIL %s_busy_len: busy_cycles=%0d want %0d", name, bcnt, cyc_exp);
    else n_pass++;
    n_chk++;
    if (o_busy !== 1'b0 || o_pass !== exp_pass || o_err !== exp_err)
      $display("FAIL %s_result: busy=%b pass=%b err=%0d want 0 %b %0d", name, o_busy, o_pass, o_err, exp_pass, exp_err);
    else n_pass++;
    n_chk++;
    if (o_ff !== exp_ff || o_vld !== exp_vld)
      $display("FAIL %s_first: ff=%0d vld=%b want %0d %b", name, o_ff, o_vld, exp_ff, exp_vld);
    else n_pass++;
    n_chk++;
    if (o_pins !== 5'd31) $display("FAIL %s_fin_pins: pins=%0d want 31", name, o_pins);
    else n_pass++;
  endtask

  task automatic test_abort_in_fin();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_chk++;
    if (o_done !== 1'b1 || o_pass !== 1'b1 || o_pins !== 5'd31)
      $display("FAIL fin_abort: done=%b pass=%b pins=%0d want 1 1 31", o_done, o_pass, o_pins);
    else n_pass++;
  endtask

  task automatic test_abort();
    sel = 1'b0; mode = 1;
    start = 1'b1; tick(); start = 1'b0;
    wait_pins(5'd10, "abort_reach_v10");
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    n_chk++;
    if (o_pins !== 5'd0 || o_busy !== 1'b0 || o_done !== 1'b0 || o_pass !== 1'b0)
      $display("FAIL abort_idle: pins=%0d busy=%b done=%b pass=%b want 0 0 0 0", o_pins, o_busy, o_done, o_pass);
    else n_pass++;
    n_chk++;
    if (o_err !== 6'd3 || o_ff !== 5'd0 || o_vld !== 1'b1)
      $display("FAIL abort_retain: err=%0d ff=%0d vld=%b want 3 0 1", o_err, o_ff, o_vld);
    else n_pass++;
    tick(); tick();
    n_chk++;
    if (o_busy !== 1'b0) $display("FAIL abort_stays_idle: busy=%b want 0", o_busy);
    else n_pass++;
    run_full(0, 1'b0, 128, 0, 1'b1, 6'd0, 5'd0, 1'b0, "restart");
  endtask

  task automatic test_reset_mid();
    sel = 1'b0; mode = 0;
    start = 1'b1; tick(); start = 1'b0;
    wait_pins(5'd20, "reset_reach_v20");
    tick();
    rst_n = 1'b0; start = 1'b1;
    tick();
    n_chk++;
    if ({o_pins, o_busy, o_done, o_pass, o_err, o_ff, o_vld} !== '0)
      $display("FAIL reset_mid: got %h want 0", {o_pins, o_busy, o_done, o_pass, o_err, o_ff, o_vld});
    else n_pass++;
    rst_n = 1'b1; start = 1'b0;
    tick();
    n_chk++;
    if (o_busy !== 1'b0 || o_pins !== 5'd0)
      $display("FAIL start_in_reset: busy=%b pins=%0d want 0 0", o_busy, o_pins);
    else n_pass++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    run_full(0, 1'b0, 128, 0, 1'b1, 6'd0, 5'd0, 1'b0, "ideal");
    test_abort_in_fin();
    run_full(1, 1'b0, 128, 0, 1'b0, 6'd7, 5'd0, 1'b1, "stuck0");
    run_full(2, 1'b0, 128, 0, 1'b0, 6'd7, 5'd1, 1'b1, "no_c1");
    test_abort();
    test_reset_mid();
    run_full(0, 1'b1, 64, 20, 1'b1, 6'd0, 5'd0, 1'b0, "settle0");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
